// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: single-outstanding instruction fetcher feeding a PC-tagged FIFO toward decode
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            Clk_i,
    input  logic            Rst_i,
    input  logic            Start_i,
    input  logic            Flush_i,
    input  logic [XLEN-1:0] PC_i,
    output logic            PCWrite_o,
    output logic            IMemReq_o,
    output logic [XLEN-1:0] IMemAddr_o,
    input  logic            IMemGnt_i,
    input  logic            IMemRvalid_i,
    input  logic [XLEN-1:0] IMemRdata_i,
    output logic [XLEN-1:0] Inst_o,
    output logic [XLEN-1:0] InstPC_o,
    output logic            InstValid_o,
    input  logic            InstReady_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic            req, grant, push, pop;

    // State register
    always_ff @(posedge Clk_i) begin
        if (Rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: at most one fetch outstanding; a killed fetch is drained before issuing again
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = grant ? WAIT : IDLE;
            WAIT:    state_next = IMemRvalid_i ? IDLE : (Flush_i ? DRAIN : WAIT);
            DRAIN:   state_next = IMemRvalid_i ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: request only from IDLE with room in the FIFO, all forced low during reset
    always_comb begin
        req         = !Rst_i && state == IDLE && Start_i && !Flush_i && count < CW'(DEPTH);
        grant       = req && IMemGnt_i;
        push        = state == WAIT && IMemRvalid_i && !Flush_i;
        pop         = count != '0 && InstReady_i;
        IMemReq_o   = req;
        PCWrite_o   = !Rst_i && (grant || Flush_i);
        IMemAddr_o  = Rst_i ? '0 : PC_i;
        InstValid_o = !Rst_i && count != '0;
        Inst_o      = Rst_i ? '0 : inst_mem[rd_ptr];
        InstPC_o    = Rst_i ? '0 : pc_mem[rd_ptr];
    end

    // Capture the PC of the granted fetch so the returning word can be tagged
    always_ff @(posedge Clk_i) begin
        if (Rst_i)      tag <= '0;
        else if (grant) tag <= PC_i;
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge Clk_i) begin
        if (Rst_i || Flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + CW'(push) - CW'(pop);
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
        end
    end

    // FIFO storage: cleared on reset, written at the tail on each push
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            inst_mem[wr_ptr] <= IMemRdata_i;
            pc_mem[wr_ptr]   <= tag;
        end
    end
endmodule
